// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.
// Produces one quotient bit per cycle and holds the {remainder, quotient} result until the instruction leaves E.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               start,
  input  logic               signed_div,
  input  logic               e_advance,
  input  logic               annul,
  output logic               stall_div,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } stateT;

  stateT            state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic             negQ;
  logic             negR;

  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH:0]   remShift;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH-1:0] nextRem;
  logic [WIDTH-1:0] nextQuo;
  logic             lastIter;

  // Magnitudes; negating the most negative value wraps to itself and is then read as unsigned.
  always_comb begin
    absA = (signed_div && a[WIDTH-1]) ? -a : a;
    absB = (signed_div && b[WIDTH-1]) ? -b : b;
  end

  // Partial remainder stays below the divisor, so one extra bit is enough to expose the borrow.
  always_comb begin
    remShift = {rem, quo[WIDTH-1]};
    diff     = remShift - {1'b0, divisor};
    borrow   = diff[WIDTH];
    nextRem  = borrow ? remShift[WIDTH-1:0] : diff[WIDTH-1:0];
    nextQuo  = {quo[WIDTH-2:0], ~borrow};
    lastIter = (cnt == CW'(WIDTH - 1));
  end

  always_comb begin
    stall_div = ~rst & ~annul & (((state == IDLE) & start) | (state == BUSY));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      ready   <= 1'b0;
      result  <= '0;
    end else if (annul) begin
      // Flush wins over every state; result keeps the last completed value.
      state <= IDLE;
      ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            divisor <= absB;
            quo     <= absA;
            rem     <= '0;
            cnt     <= '0;
            negQ    <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
            negR    <= signed_div & a[WIDTH-1];
            if (b == '0) begin
              result <= {a, {WIDTH{1'b1}}};
              ready  <= 1'b1;
              state  <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          rem <= nextRem;
          quo <= nextQuo;
          cnt <= cnt + CW'(1);
          if (lastIter) begin
            result <= {negR ? -nextRem : nextRem, negQ ? -nextQuo : nextQuo};
            ready  <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          if (e_advance) begin
            ready <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          ready <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider in the execute stage; executes DIV/DIVU.
- Its stall_div output drives the hazard unit's stall_divE input, which freezes F/D/E/M/W while the divide iterates.
- Its 64-bit {remainder, quotient} result feeds the E-stage HI/LO write path.
- One quotient bit is produced per cycle; a divide can be cancelled by exception flush.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- a  input  WIDTH  dividend (rs value after forwarding)
- b  input  WIDTH  divisor (rt value after forwarding)
- start  input  1  E-stage instruction is DIV/DIVU; held high while stalled
- signed_div  input  1  1 = DIV (signed), 0 = DIVU
- e_advance  input  1  E-stage instruction moves to M this cycle (= ~stallE)
- annul  input  1  exception flush (flush_exceptM); cancels any operation
- stall_div  output  1  divider requests a pipeline stall (combinational)
- ready  output  1  result valid for the instruction currently in E
- result  output  2*WIDTH  {hi = remainder, lo = quotient}

Behaviour:
- Reset (async, rst=1): state=IDLE, ready=0, result=0, internal registers=0. stall_div reads 0 during reset.
- States:
  - IDLE: idle.
  - BUSY: iterating; counter cnt runs 0..WIDTH-1.
  - DONE: result held until the instruction leaves E.
- IDLE with start=1 and annul=0:
  - Latch |a|, |b| (absolute values only when signed_div=1; two's-complement negate of 0x80000000 yields 0x80000000, treated as unsigned).
  - Latch neg_q = signed_div & (a[MSB] ^ b[MSB]) and neg_r = signed_div & a[MSB].
  - If b==0: go to DONE with result = {a, {WIDTH{1'b1}}}.
  - Otherwise: cnt=0, go to BUSY.
- BUSY, each cycle:
  - Form {rem, quo} shifted left by 1 and trial-subtract |b| from the upper half.
  - If no borrow: keep the difference and set quo[0]=1; else restore and set quo[0]=0.
  - cnt increments. After the iteration with cnt==WIDTH-1, go to DONE.
  - On that transition, result = {neg_r ? -rem : rem, neg_q ? -quo : quo}.
- DONE: ready=1. If e_advance=1, go to IDLE next cycle. Otherwise stay; result stays stable and no restart occurs, even though start is still high (protects against other stall sources).
- stall_div = ~annul & ((state==IDLE & start) | state==BUSY). It is 0 in DONE.
- Latency for a non-zero divisor: start seen in IDLE at cycle 0. stall_div is high for cycles 0..32 (33 cycles). Cycle 33 is DONE with ready=1 and stall_div=0.
- Zero divisor: stall_div high for 1 cycle, then DONE.
- annul=1 in any state: next state IDLE, ready=0 next cycle, stall_div=0 immediately; result is not updated by a cancelled operation.
- annul and start in the same IDLE cycle: no operation starts.
- Operands are sampled only on the IDLE→BUSY/DONE transition; changes on a/b during BUSY are ignored.
- Back-to-back divides: DONE + e_advance → IDLE. The next start (new instruction now in E) begins in IDLE, adding 1 cycle.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0; no exception.
- Reset asserted mid-BUSY: immediate return to IDLE, outputs cleared; stall_div drops.

Test Plan:
- Unsigned: DIVU a=100, b=7, start held, e_advance=0 until ready → stall_div high exactly 33 cycles; ready on cycle 33; result={32'd2, 32'd14}. Set e_advance=1 → IDLE next cycle.
- Signed signs: DIV a=-7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV a=7, b=-2 → lo=-3, hi=1.
- Edge operands:
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
  - DIVU 0xFFFFFFFF / 1 → lo=0xFFFFFFFF, hi=0.
  - b=0, a=0x1234 → stall 1 cycle; result={0x1234, 0xFFFFFFFF}.
- Annul: assert annul at BUSY cycle 10 → stall_div 0 same cycle, state IDLE next cycle, ready never asserts, result keeps its previous value. Then a new DIVU 9/3 → {0, 3} after 33 stall cycles.
- Hold in DONE: after completion keep start=1, e_advance=0 for 5 cycles → ready stays 1, stall_div stays 0, no restart, result stable. Then e_advance=1 and next start with 20/6 → {2, 3}.
- Async reset mid-BUSY (cycle 15): rst pulse between clock edges → outputs 0 immediately. After release, DIVU 50/5 completes correctly → {0, 10}.
